// File: rtl/sonic_rx_chan_40_66.sv
// sonic_rx_chan_40_66: 40-bit to 66-bit receive channel.
// A gearbox turns the 40-bit transceiver words into 66-bit candidate blocks.
// A lock FSM tests the sync headers of those blocks and slips the gearbox one
// bit at a time until the block boundary is found. A self-synchronising
// x^58 + x^39 + 1 descrambler recovers the payload. Registered results are
// presented one cycle after each candidate block.
module sonic_rx_chan_40_66 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [39:0] data_in,
    output logic [65:0] data_out,
    output logic        data_valid,
    output logic        block_lock,
    output logic        hdr_err
);

    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        TEST_SH   = 2'd1,
        SLIP_WAIT = 2'd2,
        LOCKED    = 2'd3
    } lock_state_t;

    localparam logic [6:0] WORD_BITS  = 7'd40;
    localparam logic [6:0] BLOCK_BITS = 7'd66;
    localparam logic [6:0] SH_TARGET  = 7'd64;
    localparam logic [4:0] BAD_LIMIT  = 5'd16;

    // ------------------------------------------------------------------
    // Gearbox state
    // ------------------------------------------------------------------
    // The buffer holds the bits that were not yet emitted. Bit 0 is the
    // oldest bit. Bits at and above 'fill' are always zero, so each new word
    // can simply be OR-ed in at position 'fill'. Between cycles the fill
    // count never exceeds 65. After the append it is therefore at most 105,
    // which is exactly the 105-bit buffer width. A fill count above 104
    // never has to be held.
    logic [104:0] gb_buf;
    logic [6:0]   fill;
    logic         slip_pend;

    logic [104:0] appended;
    logic [104:0] remainder;
    logic [104:0] gb_buf_next;
    logic [6:0]   fill_appended;
    logic [6:0]   fill_next;
    logic         slip_pend_next;
    logic         slip_do;

    logic         cand_valid;
    logic [65:0]  cand_blk;

    // ------------------------------------------------------------------
    // Lock FSM state
    // ------------------------------------------------------------------
    lock_state_t  state;
    logic [6:0]   sh_cnt;
    logic [4:0]   bad_cnt;
    logic         wait_cnt;

    logic         hdr_bad;
    logic [6:0]   sh_inc;
    logic [4:0]   bad_inc;
    logic         lock_loss;
    logic         slip_req;

    // ------------------------------------------------------------------
    // Descrambler state
    // ------------------------------------------------------------------
    // scr_state[57] is the most recently received scrambled payload bit.
    logic [57:0]  scr_state;
    logic [121:0] scr_hist;
    logic [63:0]  payload_descr;

    // Append the new word, emit a block when 66 bits are present, then apply
    // any slip to the bits left over.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first.
        // This keeps the block purely combinational, so no latch is inferred.
        appended       = gb_buf | ({65'd0, data_in} << fill);
        fill_appended  = fill + WORD_BITS;
        cand_valid     = (fill_appended >= BLOCK_BITS);
        cand_blk       = appended[65:0];
        remainder      = appended;
        fill_next      = fill_appended;
        slip_pend_next = 1'b0;

        if (cand_valid) begin
            remainder = appended >> 66;
            fill_next = fill_appended - BLOCK_BITS;
        end

        // Drop the oldest leftover bit. If emitting the block left nothing
        // behind, the slip is held over to the next cycle, so it is never lost.
        slip_do     = slip_req | slip_pend;
        gb_buf_next = remainder;
        if (slip_do) begin
            if (fill_next != 7'd0) begin
                gb_buf_next = remainder >> 1;
                fill_next   = fill_next - 7'd1;
            end else begin
                slip_pend_next = 1'b1;
            end
        end
    end

    // Register the gearbox buffer, its fill count and any held-over slip.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gb_buf    <= '0;
            fill      <= '0;
            slip_pend <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All
            // registers then update together at the edge, whatever the order
            // in which the blocks are written.
            gb_buf    <= gb_buf_next;
            fill      <= fill_next;
            slip_pend <= slip_pend_next;
        end
    end

    // Classify the header of the current candidate and decide whether it
    // triggers a slip or a loss of lock.
    always_comb begin
        hdr_bad   = (cand_blk[1] == cand_blk[0]);
        sh_inc    = sh_cnt + 7'd1;
        bad_inc   = bad_cnt + {4'd0, hdr_bad};
        lock_loss = 1'b0;
        slip_req  = 1'b0;
        if (cand_valid && (state == TEST_SH)) begin
            if (block_lock) begin
                lock_loss = (bad_inc == BAD_LIMIT);
                slip_req  = (bad_inc == BAD_LIMIT);
            end else begin
                slip_req  = hdr_bad;
            end
        end
    end

    // Lock FSM: count headers, slip on errors, and set or clear block_lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOCK_INIT;
            sh_cnt     <= '0;
            bad_cnt    <= '0;
            wait_cnt   <= 1'b0;
            block_lock <= 1'b0;
        end else begin
            case (state)
                LOCK_INIT: begin
                    sh_cnt   <= '0;
                    bad_cnt  <= '0;
                    wait_cnt <= 1'b0;
                    state    <= TEST_SH;
                end
                TEST_SH: begin
                    if (cand_valid) begin
                        if (slip_req) begin
                            // Loss of lock wins over the 64-block window
                            // ending on the same candidate.
                            block_lock <= 1'b0;
                            sh_cnt     <= '0;
                            bad_cnt    <= '0;
                            wait_cnt   <= 1'b0;
                            state      <= SLIP_WAIT;
                        end else if (sh_inc == SH_TARGET) begin
                            // When unlocked, reaching this point means all 64
                            // headers were good. Any bad header would have
                            // slipped.
                            sh_cnt     <= '0;
                            bad_cnt    <= '0;
                            block_lock <= 1'b1;
                            if (!block_lock) begin
                                state <= LOCKED;
                            end
                        end else begin
                            sh_cnt  <= sh_inc;
                            bad_cnt <= bad_inc;
                        end
                    end
                end
                SLIP_WAIT: begin
                    // Let two blocks at the new alignment pass before testing.
                    if (cand_valid) begin
                        if (wait_cnt) begin
                            wait_cnt <= 1'b0;
                            state    <= TEST_SH;
                        end else begin
                            wait_cnt <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    sh_cnt  <= '0;
                    bad_cnt <= '0;
                    state   <= TEST_SH;
                end
                default: begin
                    state <= LOCK_INIT;
                end
            endcase
        end
    end

    // Descramble the payload of the current candidate: for each payload bit,
    // out[i] = in[i] ^ in[i-39] ^ in[i-58], reaching back into earlier blocks.
    always_comb begin
        scr_hist      = {cand_blk[65:2], scr_state};
        payload_descr = '0;
        for (int i = 0; i < 64; i++) begin
            payload_descr[i] = scr_hist[i + 58] ^ scr_hist[i + 19] ^ scr_hist[i];
        end
    end

    // Update the descrambler history on every candidate, locked or not.
    // Register the block and its status flags one cycle after emission.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scr_state  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            hdr_err    <= 1'b0;
        end else begin
            data_valid <= cand_valid && block_lock && !lock_loss &&
                          (state != SLIP_WAIT);
            hdr_err    <= cand_valid && block_lock && hdr_bad;
            if (cand_valid) begin
                scr_state <= cand_blk[65:8];
                data_out  <= {payload_descr, cand_blk[1:0]};
            end
        end
    end

endmodule

// File: tb/tb_sonic_rx_chan_40_66.sv
// tb_sonic_rx_chan_40_66: directed bench for the 40-to-66 receive channel.
// Drives a scrambled idle-block stream (payload 64'h1E) and checks the lock
// timing, the data, header-error handling, the block cadence and reset.
module tb_sonic_rx_chan_40_66;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [39:0] data_in;
    logic [65:0] data_out;
    logic        data_valid;
    logic        block_lock;
    logic        hdr_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Stream generator: bits queued oldest first, plus the scrambler history.
    // s_hist[j] holds the scrambled bit sent j+1 bits ago.
    bit          q_bits[$];
    logic [57:0] s_hist;
    int          gen_idx;
    bit          bad_map [0:4095];

    // Timing model. The bench tracks the gearbox fill count from reset, so it
    // knows in which cycle each block comes out.
    int m_fill;
    int m_idx;
    int m_last_idx;
    int cyc;

    localparam logic [65:0] IDLE_BLK = {64'h1E, 2'b01};

    always #5 clk = ~clk;

    sonic_rx_chan_40_66 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .block_lock (block_lock),
        .hdr_err    (hdr_err)
    );

    function automatic logic [65:0] exp_blk(input int idx);
        return {64'h1E, bad_map[idx] ? 2'b00 : 2'b01};
    endfunction

    // Append one block to the stream: the header goes out unscrambled, the
    // payload goes through the x^58 + x^39 + 1 scrambler.
    function automatic void push_block();
        logic [1:0]  hdr;
        logic [63:0] p;
        logic        s;
        hdr = (gen_idx < 4096 && bad_map[gen_idx]) ? 2'b00 : 2'b01;
        p   = 64'h1E;
        q_bits.push_back(hdr[0]);
        q_bits.push_back(hdr[1]);
        for (int i = 0; i < 64; i++) begin
            s      = p[i] ^ s_hist[38] ^ s_hist[57];
            s_hist = {s_hist[56:0], s};
            q_bits.push_back(s);
        end
        gen_idx++;
    endfunction

    task automatic do_reset(input int offset);
        reset_n = 1'b0;
        data_in = '0;
        q_bits.delete();
        s_hist  = '0;
        gen_idx = 0;
        foreach (bad_map[i]) bad_map[i] = 1'b0;
        m_fill     = 0;
        m_idx      = 0;
        m_last_idx = -1;
        cyc        = 0;
        for (int i = 0; i < offset; i++) q_bits.push_back(1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Present one 40-bit word and advance the model. After the edge, the
    // outputs sampled here belong to the candidate of this cycle, if any.
    task automatic drive_cycle(output bit cand);
        logic [39:0] w;
        while (q_bits.size() < 40) push_block();
        for (int i = 0; i < 40; i++) w[i] = q_bits.pop_front();
        data_in = w;
        m_fill  = m_fill + 40;
        cand    = (m_fill >= 66);
        if (cand) begin
            m_fill     = m_fill - 66;
            m_last_idx = m_idx;
            m_idx++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (data_out !== 66'd0) begin n_mis++; $display("FAIL reset_data_out got=%h want=0", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_mis++; $display("FAIL reset_data_valid got=%b want=0", data_valid); end
        n_cmp++; if (block_lock !== 1'b0) begin n_mis++; $display("FAIL reset_block_lock got=%b want=0", block_lock); end
        n_cmp++; if (hdr_err !== 1'b0) begin n_mis++; $display("FAIL reset_hdr_err got=%b want=0", hdr_err); end
    endtask

    // Aligned stream from reset. Block n comes out in cycle ceil(66(n+1)/40),
    // so block 63 (the 64th) comes out in cycle 106 and lock rises there.
    // Cycle 107 has no candidate, and block 64 in cycle 108 is the first
    // valid one.
    task automatic test_aligned_lock();
        bit cand;
        do_reset(0);
        for (int c = 1; c <= 130; c++) begin
            drive_cycle(cand);
            n_cmp++;
            if (block_lock !== (cyc >= 106)) begin
                n_mis++; $display("FAIL aligned_lock cyc=%0d got=%b want=%b", cyc, block_lock, (cyc >= 106));
            end
            n_cmp++;
            if (data_valid !== (cand && cyc >= 107)) begin
                n_mis++; $display("FAIL aligned_valid cyc=%0d got=%b want=%b", cyc, data_valid, (cand && cyc >= 107));
            end
            if (cand && cyc >= 107) begin
                n_cmp++;
                if (data_out !== IDLE_BLK) begin
                    n_mis++; $display("FAIL aligned_data cyc=%0d got=%h want=%h", cyc, data_out, IDLE_BLK);
                end
            end
        end
        n_cmp++;
        if (cyc != 130 || m_last_idx < 64) begin
            n_mis++; $display("FAIL aligned_progress cyc=%0d last_blk=%0d want cyc=130 blk>=64", cyc, m_last_idx);
        end
    endtask

    // 330 words hold exactly 200 blocks. While locked, each one is valid.
    task automatic test_cadence();
        bit cand;
        int dv_cnt = 0;
        int err_cnt = 0;
        for (int c = 0; c < 330; c++) begin
            drive_cycle(cand);
            if (data_valid) dv_cnt++;
            if (hdr_err) err_cnt++;
            n_cmp++;
            if (data_valid !== cand) begin
                n_mis++; $display("FAIL cadence_valid cyc=%0d got=%b want=%b", cyc, data_valid, cand);
            end
            if (cand) begin
                n_cmp++;
                if (data_out !== IDLE_BLK) begin
                    n_mis++; $display("FAIL cadence_data cyc=%0d got=%h want=%h", cyc, data_out, IDLE_BLK);
                end
            end
        end
        n_cmp++; if (dv_cnt != 200) begin n_mis++; $display("FAIL cadence_count got=%0d want=200", dv_cnt); end
        n_cmp++; if (err_cnt != 0) begin n_mis++; $display("FAIL cadence_hdr_err got=%0d want=0", err_cnt); end
    endtask

    // The locked 64-block windows start at block 64. The window covering
    // blocks 320..383 gets 15 bad headers, which lock must survive.
    task automatic test_hdr_tolerate();
        bit cand;
        int err_cnt = 0;
        int n = 0;
        for (int i = 0; i < 15; i++) bad_map[322 + 2 * i] = 1'b1;
        while (!(cand && m_last_idx == 383) && n < 400) begin
            drive_cycle(cand);
            n++;
            if (hdr_err) err_cnt++;
            n_cmp++;
            if (block_lock !== 1'b1) begin
                n_mis++; $display("FAIL tolerate_lock cyc=%0d got=%b want=1", cyc, block_lock);
            end
            n_cmp++;
            if (hdr_err !== (cand && bad_map[m_last_idx])) begin
                n_mis++; $display("FAIL tolerate_hdr_err cyc=%0d got=%b want=%b", cyc, hdr_err, (cand && bad_map[m_last_idx]));
            end
            if (cand) begin
                n_cmp++;
                if (data_valid !== 1'b1 || data_out !== exp_blk(m_last_idx)) begin
                    n_mis++; $display("FAIL tolerate_data blk=%0d got=%b/%h want=1/%h", m_last_idx, data_valid, data_out, exp_blk(m_last_idx));
                end
            end
        end
        n_cmp++; if (n >= 400) begin n_mis++; $display("FAIL tolerate_timeout got=%0d cycles want<400", n); end
        n_cmp++; if (err_cnt != 15) begin n_mis++; $display("FAIL tolerate_count got=%0d want=15", err_cnt); end
    endtask

    // Window 384..447 gets 16 bad headers. The 16th, at block 416, drops
    // lock and slips one bit, so the channel stays unlocked for a long time.
    task automatic test_hdr_lose();
        bit cand;
        int err_cnt = 0;
        int n = 0;
        int bad_after = 0;
        for (int i = 0; i < 16; i++) bad_map[386 + 2 * i] = 1'b1;
        while (!(cand && m_last_idx == 416) && n < 200) begin
            drive_cycle(cand);
            n++;
            if (hdr_err) err_cnt++;
            if (!(cand && m_last_idx == 416)) begin
                n_cmp++;
                if (block_lock !== 1'b1 || data_valid !== cand) begin
                    n_mis++; $display("FAIL lose_before cyc=%0d lock=%b valid=%b want lock=1 valid=%b", cyc, block_lock, data_valid, cand);
                end
            end
        end
        n_cmp++; if (n >= 200) begin n_mis++; $display("FAIL lose_timeout got=%0d cycles want<200", n); end
        n_cmp++; if (block_lock !== 1'b0) begin n_mis++; $display("FAIL lose_lock got=%b want=0", block_lock); end
        n_cmp++; if (hdr_err !== 1'b1) begin n_mis++; $display("FAIL lose_hdr_err got=%b want=1", hdr_err); end
        n_cmp++; if (data_valid !== 1'b0) begin n_mis++; $display("FAIL lose_valid got=%b want=0", data_valid); end
        n_cmp++; if (err_cnt != 16) begin n_mis++; $display("FAIL lose_count got=%0d want=16", err_cnt); end
        for (int c = 0; c < 150; c++) begin
            drive_cycle(cand);
            if (block_lock !== 1'b0 || data_valid !== 1'b0) bad_after++;
        end
        n_cmp++; if (bad_after != 0) begin n_mis++; $display("FAIL lose_stays_unlocked got=%0d locked cycles want=0", bad_after); end
    endtask

    // A stream offset by 17 bits must be found by slipping, with no valid data
    // before lock. After lock the data is clean idle.
    task automatic test_offset();
        bit cand;
        int n = 0;
        int early_dv = 0;
        int dv_cnt = 0;
        int bad_data = 0;
        int unlock = 0;
        do_reset(17);
        while (block_lock !== 1'b1 && n < 4000) begin
            drive_cycle(cand);
            n++;
            if (data_valid === 1'b1 && block_lock !== 1'b1) early_dv++;
        end
        n_cmp++; if (block_lock !== 1'b1) begin n_mis++; $display("FAIL offset_lock got=%b after %0d cycles want=1", block_lock, n); end
        n_cmp++; if (early_dv != 0) begin n_mis++; $display("FAIL offset_early_valid got=%0d want=0", early_dv); end
        for (int c = 0; c < 60; c++) begin
            drive_cycle(cand);
            if (block_lock !== 1'b1) unlock++;
            if (data_valid) begin
                dv_cnt++;
                if (data_out !== IDLE_BLK) bad_data++;
            end
        end
        n_cmp++; if (unlock != 0) begin n_mis++; $display("FAIL offset_hold got=%0d unlocked cycles want=0", unlock); end
        n_cmp++; if (bad_data != 0) begin n_mis++; $display("FAIL offset_data got=%0d bad blocks want=0", bad_data); end
        n_cmp++; if (dv_cnt < 36 || dv_cnt > 37) begin n_mis++; $display("FAIL offset_valid_count got=%0d want=36..37", dv_cnt); end
    endtask

    // Reset in the middle of a cycle clears the outputs at once. Aligned
    // acquisition then restarts from an empty buffer and locks in cycle 106.
    task automatic test_reset_mid();
        bit cand;
        int dv_seen = 0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (data_out !== 66'd0) begin n_mis++; $display("FAIL mid_reset_data_out got=%h want=0", data_out); end
        n_cmp++; if (data_valid !== 1'b0) begin n_mis++; $display("FAIL mid_reset_data_valid got=%b want=0", data_valid); end
        n_cmp++; if (block_lock !== 1'b0) begin n_mis++; $display("FAIL mid_reset_block_lock got=%b want=0", block_lock); end
        n_cmp++; if (hdr_err !== 1'b0) begin n_mis++; $display("FAIL mid_reset_hdr_err got=%b want=0", hdr_err); end
        do_reset(0);
        for (int c = 1; c <= 108; c++) begin
            drive_cycle(cand);
            if (cyc <= 107 && data_valid) dv_seen++;
            if (cyc == 105) begin
                n_cmp++; if (block_lock !== 1'b0) begin n_mis++; $display("FAIL relock_early got=%b want=0", block_lock); end
            end
            if (cyc == 106) begin
                n_cmp++; if (block_lock !== 1'b1) begin n_mis++; $display("FAIL relock got=%b want=1", block_lock); end
            end
            if (cyc == 108) begin
                n_cmp++;
                if (data_valid !== 1'b1 || data_out !== IDLE_BLK) begin
                    n_mis++; $display("FAIL relock_data got=%b/%h want=1/%h", data_valid, data_out, IDLE_BLK);
                end
            end
        end
        n_cmp++; if (dv_seen != 0) begin n_mis++; $display("FAIL relock_early_valid got=%0d want=0", dv_seen); end
    endtask

    initial begin
        test_reset();
        test_aligned_lock();
        test_cadence();
        test_hdr_tolerate();
        test_hdr_lose();
        test_offset();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
